// File: rtl/waveform_stream_if.sv
// Bus bundle between the waveform streamer, its RAM read port and the DAC SPI master.
interface waveform_stream_if #(
    parameter int unsigned RAM_WID      = 32,
    parameter int unsigned RAM_WORD_WID = 16,
    parameter int unsigned DAC_WID      = 24
) ();
    logic [RAM_WID-1:0]      ram_dma_addr;
    logic                    ram_read;
    logic                    ram_valid;
    logic [RAM_WORD_WID-1:0] ram_word;
    logic [DAC_WID-1:0]      dac_data;
    logic                    dac_arm;
    logic                    dac_finished;

    modport master (
        output ram_dma_addr, ram_read, dac_data, dac_arm,
        input  ram_valid, ram_word, dac_finished
    );

    modport slave (
        input  ram_dma_addr, ram_read, dac_data, dac_arm,
        output ram_valid, ram_word, dac_finished
    );
endinterface

// File: rtl/waveform_stream.sv
// Streams a sample table from RAM to a DAC at a fixed sample period,
// with a small prefetch FIFO between the RAM fetcher and the DAC player.
module waveform_stream #(
    parameter int unsigned DAC_WID         = 24,
    parameter int unsigned WORD_WID        = 20,
    parameter logic [DAC_WID-WORD_WID-1:0] DAC_CMD = 4'b0001,
    parameter int unsigned RAM_WID         = 32,
    parameter int unsigned RAM_WORD_WID    = 16,
    parameter int unsigned RAM_WORD_INCR   = 2,
    parameter int unsigned WORD_AMNT_WID   = 11,
    parameter int unsigned TIMER_WID       = 32,
    parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic                     loop_mode,
    input  logic [RAM_WID-1:0]       start_addr,
    input  logic [WORD_AMNT_WID-1:0] word_amnt,
    input  logic [TIMER_WID-1:0]     time_to_wait,
    output logic                     running,
    output logic                     finished,
    output logic                     underrun,
    waveform_stream_if.master        bus
);
    localparam int unsigned DEPTH  = 2 ** FIFO_DEPTH_LOG2;
    localparam int unsigned HI_WID = WORD_WID - RAM_WORD_WID;
    localparam logic [RAM_WID-1:0] ADDR_STEP   = RAM_WID'(RAM_WORD_INCR);
    localparam logic [RAM_WID-1:0] SAMPLE_STEP = RAM_WID'(2 * RAM_WORD_INCR);
    localparam logic [FIFO_DEPTH_LOG2:0] FIFO_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOP, ST_DONE} state_t;

    state_t state, state_next;

    logic                     arm_q, loop_q;
    logic [RAM_WID-1:0]       base_addr, fetch_addr;
    logic [WORD_AMNT_WID-1:0] amnt_q, fetch_k, play_issued;
    logic [TIMER_WID-1:0]     wait_q, timer;
    logic                     fetch_busy, fetch_half, push_pending, played_any;
    logic [RAM_WORD_WID-1:0]  low_q;
    logic [HI_WID-1:0]        high_q;

    logic [WORD_WID-1:0]        fifo_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   fifo_count;

    logic start_edge, start_run, run_active, last_done;
    logic fetch_issue, high_issue, push, pop, under_now, more_to_play;

    // Control decode shared by fetcher, FIFO and player
    always_comb begin
        start_edge   = arm && !arm_q;
        start_run    = (state == ST_IDLE) && start_edge;
        run_active   = (state == ST_RUN) && arm;
        more_to_play = loop_q || (play_issued < amnt_q);
        // one sample in flight at most, so "in flight" is fetch_busy itself
        fetch_issue  = run_active && !fetch_busy && (loop_q || (fetch_k < amnt_q))
                       && (fifo_count < FIFO_FULL);
        high_issue   = run_active && fetch_busy && fetch_half && !bus.ram_read && !push_pending;
        push         = push_pending && (state == ST_RUN);
        pop          = run_active && !bus.dac_arm && (timer == '0) && (fifo_count != '0) && more_to_play;
        // the initial fill is not an underrun: only count once playback has begun
        under_now    = run_active && !bus.dac_arm && (timer == '0) && (fifo_count == '0)
                       && played_any && more_to_play;
        last_done    = !loop_q && bus.dac_arm && bus.dac_finished && (play_issued == amnt_q);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state and status outputs
    always_comb begin
        state_next = state;
        running    = 1'b0;
        finished   = 1'b0;
        case (state)
            ST_IDLE: if (start_edge) state_next = (word_amnt == '0) ? ST_DONE : ST_RUN;
            ST_RUN: begin
                running = 1'b1;
                if (!arm)           state_next = ST_STOP;
                else if (last_done) state_next = ST_DONE;
            end
            ST_STOP: begin
                running = 1'b1;
                if (!bus.ram_read && !bus.dac_arm) state_next = ST_IDLE;
            end
            ST_DONE: begin
                finished = 1'b1;
                if (!arm) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Arm edge detector and start-time configuration latch
    always_ff @(posedge clk) begin
        if (rst) begin
            arm_q     <= 1'b0;
            loop_q    <= 1'b0;
            base_addr <= '0;
            amnt_q    <= '0;
            wait_q    <= '0;
        end else begin
            arm_q <= arm;
            if (start_run) begin
                loop_q    <= loop_mode;
                base_addr <= start_addr;
                amnt_q    <= word_amnt;
                wait_q    <= time_to_wait;
            end
        end
    end

    // RAM fetcher: low word, one idle cycle, high word, then push
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ram_read     <= 1'b0;
            bus.ram_dma_addr <= '0;
            fetch_busy       <= 1'b0;
            fetch_half       <= 1'b0;
            push_pending     <= 1'b0;
            fetch_addr       <= '0;
            fetch_k          <= '0;
            low_q            <= '0;
            high_q           <= '0;
        end else if (start_run) begin
            fetch_busy   <= 1'b0;
            fetch_half   <= 1'b0;
            push_pending <= 1'b0;
            fetch_addr   <= start_addr;
            fetch_k      <= '0;
        end else begin
            push_pending <= 1'b0;
            if (bus.ram_read) begin
                if (bus.ram_valid) begin
                    bus.ram_read <= 1'b0;
                    if (!fetch_half) begin
                        low_q      <= bus.ram_word;
                        fetch_half <= 1'b1;
                    end else begin
                        high_q       <= bus.ram_word[HI_WID-1:0];
                        push_pending <= 1'b1;
                    end
                end
            end else if (fetch_issue) begin
                bus.ram_read     <= 1'b1;
                bus.ram_dma_addr <= fetch_addr;
                fetch_busy       <= 1'b1;
            end else if (high_issue) begin
                bus.ram_read     <= 1'b1;
                bus.ram_dma_addr <= fetch_addr + ADDR_STEP;
            end
            if (push_pending) begin
                fetch_busy <= 1'b0;
                fetch_half <= 1'b0;
                if (loop_q && (fetch_k == amnt_q - 1'b1)) begin
                    fetch_k    <= '0;
                    fetch_addr <= base_addr;
                end else begin
                    fetch_k    <= fetch_k + 1'b1;
                    fetch_addr <= fetch_addr + SAMPLE_STEP;
                end
            end
        end
    end

    // Prefetch FIFO; emptied on start and throughout STOP
    always_ff @(posedge clk) begin
        if (rst || start_run || (state == ST_STOP)) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {high_q, low_q};
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // DAC player: sample period timer, DAC handshake and underrun flag
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.dac_arm  <= 1'b0;
            bus.dac_data <= '0;
            timer        <= '0;
            underrun     <= 1'b0;
            play_issued  <= '0;
            played_any   <= 1'b0;
        end else if (start_run) begin
            timer       <= '0;
            underrun    <= 1'b0;
            play_issued <= '0;
            played_any  <= 1'b0;
        end else begin
            if (timer != '0) timer <= timer - 1'b1;
            if (bus.dac_arm) begin
                if (bus.dac_finished) bus.dac_arm <= 1'b0;
            end else if (pop) begin
                bus.dac_arm  <= 1'b1;
                bus.dac_data <= {DAC_CMD, fifo_mem[rd_ptr]};
                timer        <= wait_q;
                played_any   <= 1'b1;
                if (!loop_q) play_issued <= play_issued + 1'b1;
            end
            if (under_now) underrun <= 1'b1;
        end
    end
endmodule

// File: doc/waveform_stream.md
WAVEFORM_STREAM -- requirements
Module: waveform_stream

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DAC_WID, 24: DAC word width.
- WORD_WID, 20: sample width; RAM_WORD_WID < WORD_WID <= 2*RAM_WORD_WID.
- DAC_CMD, 4'b0001: prefix of width DAC_WID-WORD_WID.
- RAM_WID, 32: RAM address width.
- RAM_WORD_WID, 16: RAM data width.
- RAM_WORD_INCR, 2: address step per RAM word.
- WORD_AMNT_WID, 11: sample count width.
- TIMER_WID, 32: sample period width.
- FIFO_DEPTH_LOG2, 3: prefetch FIFO depth = 2**FIFO_DEPTH_LOG2.
REQ-002 Ports (name direction width meaning):
- clk in 1: the only clock.
- rst in 1: synchronous, active-high reset.
- arm in 1: level; rising edge starts, low stops.
- loop_mode in 1: 1 = repeat table; sampled at start.
- start_addr in RAM_WID: table base; sampled at start.
- word_amnt in WORD_AMNT_WID: samples in table; sampled at start.
- time_to_wait in TIMER_WID: cycles between DAC arms; sampled at start.
- running out 1: high in RUN/STOP.
- finished out 1: one-shot done.
- underrun out 1: sticky; FIFO empty when sample due.
- ram_dma_addr out RAM_WID: read address.
- ram_read out 1: read request.
- ram_valid in 1: one-cycle strobe; ram_word valid.
- ram_word in RAM_WORD_WID: read data.
- dac_data out DAC_WID: word to SPI master.
- dac_arm out 1: DAC transfer request.
- dac_finished in 1: SPI master transfer done.

Function
REQ-003 States: IDLE, RUN, STOP, DONE; IDLE->RUN on arm 0->1 (registered edge); other inputs latched that cycle.
REQ-004 Start with word_amnt==0: IDLE->DONE, no RAM reads, finished=1 next cycle.
REQ-005 Fetch: sample k uses RAM words at start_addr+(2k)*RAM_WORD_INCR (low) and +(2k+1)*RAM_WORD_INCR (high); one request outstanding at a time.
REQ-006 RAM handshake: ram_read and ram_dma_addr held stable from assertion until the cycle ram_valid=1; ram_read low the following cycle at minimum.
REQ-007 Assembly: sample = {high[WORD_WID-RAM_WORD_WID-1:0], low}; pushed to FIFO the cycle after the high word's ram_valid.
REQ-008 Fetcher issues a new sample fetch only if FIFO occupancy plus in-flight samples < depth; never overflows.
REQ-009 One-shot: fetch stops after word_amnt samples; loop: after sample word_amnt-1, k wraps to 0 (address back to start_addr).
REQ-010 Player: timer loads time_to_wait at each dac_arm assertion, decrements to 0; first sample due immediately on entering RUN.
REQ-011 When timer==0, DAC idle and FIFO non-empty: pop; dac_data={DAC_CMD, sample}; dac_arm=1 held until dac_finished, dropped the same cycle; dac_data stable while dac_arm=1.
REQ-012 Sample due, DAC idle, FIFO empty: underrun=1 (sticky until next start or rst); sample issued as soon as FIFO non-empty.
REQ-013 Simultaneous FIFO push and pop in one cycle: both succeed, occupancy unchanged.
REQ-014 One-shot: after word_amnt-th dac_finished: RUN->DONE, running=0, finished=1.
REQ-015 DONE->IDLE when arm=0; finished cleared on leaving DONE.
REQ-016 arm=0 in RUN (either mode): ->STOP; no new fetch or DAC arm; complete outstanding RAM read and active DAC transfer; flush FIFO; ->IDLE.
REQ-017 Elapsed cycles between consecutive dac_arm rises >= max(time_to_wait, DAC transfer time); time_to_wait=0 means back-to-back.

Reset
REQ-018 rst=1 at any clock edge: state=IDLE; running, finished, underrun, ram_read, dac_arm=0; dac_data, ram_dma_addr=0; FIFO empty; timer=0; arm edge detector cleared.
REQ-019 rst mid-operation abandons outstanding RAM read and DAC transfer; a stale ram_valid/dac_finished in IDLE is ignored.

Verification
REQ-020 One-shot, start_addr=0x12340, word_amnt=3, time_to_wait=50, zero-wait RAM -> reads 0x12340..0x1234A step 2; three dac_data={4'h1,sample}; arm rises >=50 cycles apart; finished=1, underrun=0.
REQ-021 Loop, word_amnt=2, arm held for 6 samples -> sample order 0,1,0,1,0,1; address wraps to start_addr; finished never set.
REQ-022 RAM latency 40 cycles, time_to_wait=10 -> underrun=1 and sticky; every sample still emitted in order, none dropped or duplicated.
REQ-023 arm=0 during an active DAC transfer in loop mode -> dac_arm held until dac_finished, no further reads or arms, IDLE with FIFO empty, running=0.
REQ-024 word_amnt=0 -> finished=1 one cycle after start, ram_read never asserted; arm=0 returns IDLE.
REQ-025 rst pulse while ram_read=1 -> next cycle all outputs at REQ-018 values; late ram_valid produces no FIFO push.
